// File: rtl/dffnsre_bank_arb.sv
// Round-robin write arbiter for a shared DFFNSRE/LUT register bank: clears the
// bank after reset, sequences D/sel/E per transaction and checks Q readback.
module dffnsre_bank_arb #(
  parameter int unsigned NREQ        = 4,
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned INIT_CYCLES = 2
) (
  input  logic                    C,
  input  logic                    R,
  input  logic                    clr,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*WIDTH-1:0]   wdata,
  output logic [NREQ-1:0]         gnt,
  output logic [NREQ-1:0]         done,
  output logic                    cmp_err,
  output logic [7:0]              err_cnt,
  output logic                    busy,
  output logic [WIDTH-1:0]        bank_D,
  output logic                    bank_E,
  output logic                    bank_sel,
  output logic                    bank_Rn,
  output logic                    bank_Sn,
  input  logic [WIDTH-1:0]        bank_Q
);

  localparam int unsigned PW  = (NREQ > 2) ? $clog2(NREQ) : 1;
  localparam int unsigned PW1 = PW + 1;
  localparam int unsigned CW  = 4;

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_LOAD,
    S_WRITE,
    S_CHECK
  } state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     init_cnt_q, init_cnt_d;
  logic [PW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [PW-1:0]     gidx_q, gidx_d;
  logic [WIDTH-1:0]  hold_q, hold_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [NREQ-1:0]   done_q, done_d;
  logic              cmp_err_q, cmp_err_d;
  logic [7:0]        err_cnt_q, err_cnt_d;
  logic              busy_q, busy_d;
  logic [WIDTH-1:0]  bank_D_q, bank_D_d;
  logic              bank_E_q, bank_E_d;
  logic              bank_sel_q, bank_sel_d;
  logic              bank_Rn_q, bank_Rn_d;

  logic              pick_valid;
  logic [PW-1:0]     pick_idx;
  logic [PW1-1:0]    scan_idx;

  // First pending requester scanning upward from rr_ptr, wrapping at NREQ.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    scan_idx   = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      scan_idx = {1'b0, rr_ptr_q} + PW1'(i);
      if (scan_idx >= PW1'(NREQ)) scan_idx = scan_idx - PW1'(NREQ);
      if (!pick_valid && req[scan_idx[PW-1:0]]) begin
        pick_valid = 1'b1;
        pick_idx   = scan_idx[PW-1:0];
      end
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    rr_ptr_d   = rr_ptr_q;
    gidx_d     = gidx_q;
    hold_d     = hold_q;
    gnt_d      = gnt_q;
    done_d     = '0;
    cmp_err_d  = 1'b0;
    err_cnt_d  = err_cnt_q;

    case (state_q)
      S_INIT: begin
        init_cnt_d = init_cnt_q + CW'(1);
        if (init_cnt_q >= CW'(INIT_CYCLES - 1)) begin
          state_d    = S_IDLE;
          init_cnt_d = '0;
        end
      end
      S_IDLE: begin
        if (clr) begin
          state_d    = S_INIT;
          init_cnt_d = '0;
        end else if (pick_valid) begin
          state_d = S_LOAD;
          gnt_d   = NREQ'(1) << pick_idx;
          gidx_d  = pick_idx;
          hold_d  = wdata[pick_idx*WIDTH +: WIDTH];
        end
      end
      S_LOAD: begin
        state_d = S_WRITE;
      end
      S_WRITE: begin
        // Bank captured on the negedge inside WRITE; Q is settled by this edge.
        state_d = S_CHECK;
        done_d  = gnt_q;
        if (bank_Q != hold_q) begin
          cmp_err_d = 1'b1;
          if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
        end
      end
      S_CHECK: begin
        state_d  = S_IDLE;
        gnt_d    = '0;
        rr_ptr_d = (gidx_q == PW'(NREQ - 1)) ? '0 : gidx_q + PW'(1);
      end
      default: begin
        state_d = S_INIT;
      end
    endcase

    busy_d     = (state_d != S_IDLE);
    bank_Rn_d  = (state_d != S_INIT);
    bank_E_d   = (state_d == S_WRITE);
    bank_sel_d = (state_d == S_LOAD) || (state_d == S_WRITE) || (state_d == S_CHECK);
    bank_D_d   = (state_d == S_LOAD) ? hold_d : bank_D_q;
  end

  always_ff @(posedge C or negedge R) begin
    if (!R) begin
      state_q    <= S_INIT;
      init_cnt_q <= '0;
      rr_ptr_q   <= '0;
      gidx_q     <= '0;
      hold_q     <= '0;
      gnt_q      <= '0;
      done_q     <= '0;
      cmp_err_q  <= 1'b0;
      err_cnt_q  <= '0;
      busy_q     <= 1'b1;
      bank_D_q   <= '0;
      bank_E_q   <= 1'b0;
      bank_sel_q <= 1'b0;
      bank_Rn_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      rr_ptr_q   <= rr_ptr_d;
      gidx_q     <= gidx_d;
      hold_q     <= hold_d;
      gnt_q      <= gnt_d;
      done_q     <= done_d;
      cmp_err_q  <= cmp_err_d;
      err_cnt_q  <= err_cnt_d;
      busy_q     <= busy_d;
      bank_D_q   <= bank_D_d;
      bank_E_q   <= bank_E_d;
      bank_sel_q <= bank_sel_d;
      bank_Rn_q  <= bank_Rn_d;
    end
  end

  assign gnt      = gnt_q;
  assign done     = done_q;
  assign cmp_err  = cmp_err_q;
  assign err_cnt  = err_cnt_q;
  assign busy     = busy_q;
  assign bank_D   = bank_D_q;
  assign bank_E   = bank_E_q;
  assign bank_sel = bank_sel_q;
  assign bank_Rn  = bank_Rn_q;
  assign bank_Sn  = 1'b1;

endmodule
